mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port. It accepts mem_rden/mem_wren requests with address and size, and services them from an internal word-organised RAM after programmable wait states.
- It returns a one-cycle mem_ready pulse with right-aligned read data.
- It sits between the core and the simulation/FPGA memory. It is the target end of the core's memory interface.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_responder.sv | 159 +++++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory responder and its lane-alignment helper.
package mem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a right-aligned bus value and a 32-bit RAM word.
// Produces write byte enables, a lane-replicated write word, and the
// right-aligned, zero-extended read lane. Size 3 yields no enables and zero data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0] addr_lo_i,
  input  logic [1:0] size_i,
  input  word_t      wdata_i,
  input  word_t      rword_i,
  output logic [3:0] be_o,
  output word_t      wword_o,
  output word_t      rdata_o
);

  word_t shifted;

  // Decode size/offset into enables, replicated store data and the load lane.
  always_comb begin
    be_o    = 4'b0000;
    wword_o = '0;
    rdata_o = '0;
    shifted = rword_i >> {addr_lo_i, 3'b000};
    case (size_i)
      MEM_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, shifted[7:0]};
      end
      MEM_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, shifted[15:0]};
      end
      MEM_W: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a load/store request, waits WAIT_STATES
// cycles, then services it from an internal word RAM with a one-cycle
// mem_ready pulse. Optional macro MEM_RESP_MISALIGN_TRAP_EN turns misaligned
// half/word accesses into errors; without it the low address bits are aligned.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rden,
  input  logic        mem_wren,
  input  logic [1:0]  mem_size,
  input  logic [31:0] memwrite_data,
  output logic [31:0] memread_data,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS * WORD_BYTES);

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        load, enter_resp;

  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        rd_q, wr_q;
  logic        ready_q, err_q;
  word_t       rdata_q;

  word_t       mem_q [DEPTH_WORDS];

  // With zero wait states RESP is entered on the capture edge itself, so the
  // access must be evaluated from the live inputs while still in IDLE.
  logic        in_idle;
  logic [31:0] src_addr, src_wdata, off;
  logic [1:0]  src_size, lane_lo;
  logic        src_rd, src_wr, out_of_range, err, we;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  word_t       wword, lane_rdata;

  assign in_idle   = (state_q == IDLE);
  assign src_addr  = in_idle ? mem_addr      : addr_q;
  assign src_wdata = in_idle ? memwrite_data : wdata_q;
  assign src_size  = in_idle ? mem_size      : size_q;
  assign src_rd    = in_idle ? mem_rden      : rd_q;
  assign src_wr    = in_idle ? mem_wren      : wr_q;

  assign off          = src_addr - BASE_ADDR;
  assign out_of_range = (src_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
  assign idx          = off[AW+1:2];

`ifdef MEM_RESP_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((src_size == MEM_H) && src_addr[0]) ||
                    ((src_size == MEM_W) && (src_addr[1:0] != 2'b00));
  assign lane_lo  = src_addr[1:0];
  assign err      = out_of_range || (src_size == 2'd3) || (src_rd && src_wr) || misalign;
`else
  assign lane_lo  = (src_size == MEM_H) ? {src_addr[1], 1'b0} :
                    (src_size == MEM_W) ? 2'b00 : src_addr[1:0];
  assign err      = out_of_range || (src_size == 2'd3) || (src_rd && src_wr);
`endif

  mem_lane_align u_align (
    .addr_lo_i (lane_lo),
    .size_i    (src_size),
    .wdata_i   (src_wdata),
    .rword_i   (mem_q[idx]),
    .be_o      (be),
    .wword_o   (wword),
    .rdata_o   (lane_rdata)
  );

  // Next-state logic: IDLE captures, WAIT counts down, RESP always returns.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_rden || mem_wren) begin
          load = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request capture and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q  <= mem_addr;
        wdata_q <= memwrite_data;
        size_q  <= mem_size;
        rd_q    <= mem_rden;
        wr_q    <= mem_wren;
      end
      ready_q <= enter_resp;
      err_q   <= enter_resp && err;
      rdata_q <= (enter_resp && src_rd && !err) ? lane_rdata : '0;
    end
  end

  // Gating on rst drops a store whose commit edge coincides with reset.
  assign we = enter_resp && src_wr && !err && !rst;

  // RAM byte-lane commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign mem_ready    = ready_q;
  assign mem_err      = err_q;
  assign memread_data = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (one wait state at base 0, zero wait
// states at a non-zero base) checked against a byte-addressed reference model.
module tb_mem_responder;

  localparam int          A_DEPTH = 1024;
  localparam logic [31:0] A_BASE  = 32'h0000_0000;
  localparam int          A_WS    = 1;
  localparam int          B_DEPTH = 256;
  localparam logic [31:0] B_BASE  = 32'h0001_0000;
  localparam int          B_WS    = 0;
`ifdef MEM_RESP_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_addr = '0, a_wd = '0, a_rdata;
  logic        a_rd = 1'b0, a_wr = 1'b0, a_ready, a_err;
  logic [1:0]  a_size = 2'd0;
  logic [31:0] b_addr = '0, b_wd = '0, b_rdata;
  logic        b_rd = 1'b0, b_wr = 1'b0, b_ready, b_err;
  logic [1:0]  b_size = 2'd0;

  mem_responder #(.DEPTH_WORDS(A_DEPTH), .BASE_ADDR(A_BASE), .WAIT_STATES(A_WS)) u_dut_a (
    .clk(clk), .rst(rst), .mem_addr(a_addr), .mem_rden(a_rd), .mem_wren(a_wr),
    .mem_size(a_size), .memwrite_data(a_wd), .memread_data(a_rdata),
    .mem_ready(a_ready), .mem_err(a_err));

  mem_responder #(.DEPTH_WORDS(B_DEPTH), .BASE_ADDR(B_BASE), .WAIT_STATES(B_WS)) u_dut_b (
    .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_rden(b_rd), .mem_wren(b_wr),
    .mem_size(b_size), .memwrite_data(b_wd), .memread_data(b_rdata),
    .mem_ready(b_ready), .mem_err(b_err));

  int errors = 0;
  int checks = 0;
  bit [7:0] mdl [longint];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed memory model: applies the access rules directly.
  function automatic void model(input int sel, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wd, output logic err,
                                output logic [31:0] d);
    longint base = (sel == 0) ? A_BASE : B_BASE;
    longint span = ((sel == 0) ? A_DEPTH : B_DEPTH) * 4;
    longint a    = addr;
    int     n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (rd && wr) || (size == 2'd3) || (a < base) || (a >= base + span);
    if (size != 2'd3 && (a % n) != 0) begin
      if (TRAP) err = 1'b1;
      else a = a - (a % n);
    end
    d = '0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        longint k = longint'(sel) * 64'h1_0000_0000 + a + i;
        if (rd) d[8*i +: 8] = mdl.exists(k) ? mdl[k] : 8'h00;
        else if (wr) mdl[k] = wd[8*i +: 8];
      end
    end
  endfunction

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] wd);
    if (sel == 0) begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_size = size; a_wd = wd;
    end else begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_size = size; b_wd = wd;
    end
  endtask

  task automatic txn(input int sel, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [1:0] size, input logic [31:0] wd, input string tag);
    logic eerr, gerr, grdy;
    logic [31:0] edata, gdata;
    int cyc = 0;
    model(sel, rd, wr, addr, size, wd, eerr, edata);
    @(negedge clk);
    drive(sel, rd, wr, addr, size, wd);
    grdy = 1'b0; gerr = 1'b0; gdata = '0;
    while (!grdy && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      grdy  = (sel == 0) ? a_ready : b_ready;
      gerr  = (sel == 0) ? a_err   : b_err;
      gdata = (sel == 0) ? a_rdata : b_rdata;
    end
    drive(sel, 1'b0, 1'b0, addr, size, wd);
    chk({tag, " latency"}, 32'(cyc), 32'(1 + ((sel == 0) ? A_WS : B_WS)));
    chk({tag, " err"}, {31'b0, gerr}, {31'b0, eerr});
    if (rd) chk({tag, " data"}, gdata, edata);
    @(posedge clk); #1;
    chk({tag, " pulse_len"}, {31'b0, (sel == 0) ? a_ready : b_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e; logic [31:0] d;
    int pulses, first_gap;

    // Reset state
    #12;
    chk("rst a_ready", {31'b0, a_ready}, 32'd0);
    chk("rst a_err",   {31'b0, a_err},   32'd0);
    chk("rst a_rdata", a_rdata,          32'd0);
    chk("rst b_ready", {31'b0, b_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Word write/read
    txn(0, 0, 1, 32'h100, 2'd2, 32'hDEADBEEF, "w100");
    txn(0, 1, 0, 32'h100, 2'd2, 32'h0,        "r100");
    // Byte/half lanes
    txn(0, 0, 1, 32'h200, 2'd2, 32'h11223344, "w200");
    txn(0, 0, 1, 32'h202, 2'd0, 32'hFFFF_FFAB, "wb202");
    txn(0, 1, 0, 32'h200, 2'd2, 32'h0, "r200");
    txn(0, 1, 0, 32'h202, 2'd1, 32'h0, "rh202");
    txn(0, 1, 0, 32'h203, 2'd0, 32'h0, "rb203");
    // Errors
    txn(0, 1, 0, A_BASE + A_DEPTH*4, 2'd2, 32'h0, "r_oor");
    txn(0, 0, 1, 32'h200, 2'd3, 32'hFFFF_FFFF, "w_size3");
    txn(0, 1, 0, 32'h200, 2'd2, 32'h0, "r200_after_size3");
    txn(0, 1, 1, 32'h100, 2'd2, 32'h12345678, "rdwr_both");
    txn(0, 1, 0, 32'h100, 2'd2, 32'h0, "r100_after_both");
    // Misalignment
    txn(0, 0, 1, 32'h300, 2'd2, 32'h01020304, "w300");
    txn(0, 0, 1, 32'h301, 2'd1, 32'h0000BEEF, "wh301");
    txn(0, 1, 0, 32'h300, 2'd2, 32'h0, "r300");
    txn(0, 1, 0, 32'h303, 2'd2, 32'h0, "rw303");
    // Range boundaries on the non-zero-base instance
    txn(1, 0, 1, B_BASE + B_DEPTH*4 - 4, 2'd2, 32'hCAFEF00D, "b_wlast");
    txn(1, 1, 0, B_BASE + B_DEPTH*4 - 1, 2'd0, 32'h0, "b_rlastbyte");
    txn(1, 1, 0, B_BASE + B_DEPTH*4,     2'd0, 32'h0, "b_rpast");
    txn(1, 1, 0, B_BASE - 1,             2'd0, 32'h0, "b_rbelow");
    txn(1, 0, 1, B_BASE + 32'h40, 2'd2, 32'h0, "b_init40");
    txn(1, 0, 1, B_BASE + 32'h44, 2'd2, 32'h0, "b_init44");

    // Back-to-back on zero-wait-state instance
    model(1, 0, 1, B_BASE + 32'h40, 2'd2, 32'hA5A5_0001, e, d);
    model(1, 0, 1, B_BASE + 32'h44, 2'd2, 32'h5A5A_0002, e, d);
    @(negedge clk);
    drive(1, 0, 1, B_BASE + 32'h40, 2'd2, 32'hA5A5_0001);
    @(posedge clk); #1;
    chk("b2b first pulse", {31'b0, b_ready}, 32'd1);
    b_wd = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("b2b gap", {31'b0, b_ready}, 32'd0);
    drive(1, 0, 1, B_BASE + 32'h44, 2'd2, 32'h5A5A_0002);
    first_gap = 0;
    @(posedge clk); #1;
    first_gap = b_ready ? 2 : 0;
    chk("b2b second pulse spacing", 32'(first_gap), 32'd2);
    drive(1, 0, 0, B_BASE + 32'h44, 2'd2, 32'h0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (b_ready) pulses++;
    end
    chk("b2b no extra pulses", 32'(pulses), 32'd0);
    txn(1, 1, 0, B_BASE + 32'h40, 2'd2, 32'h0, "b2b rA");
    txn(1, 1, 0, B_BASE + 32'h44, 2'd2, 32'h0, "b2b rB");

    // Reset during WAIT drops the store
    txn(0, 0, 1, 32'h400, 2'd2, 32'h99887766, "w400");
    @(negedge clk);
    drive(0, 0, 1, 32'h400, 2'd0, 32'h55);
    @(posedge clk); #1;
    chk("midrst in wait", {31'b0, a_ready}, 32'd0);
    rst = 1'b1; #1;
    chk("midrst ready", {31'b0, a_ready}, 32'd0);
    chk("midrst rdata", a_rdata, 32'd0);
    drive(0, 0, 0, 32'h400, 2'd0, 32'h0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (a_ready) pulses++;
    end
    chk("midrst no pulse", 32'(pulses), 32'd0);
    @(negedge clk); rst = 1'b0;
    txn(0, 1, 0, 32'h400, 2'd2, 32'h0, "r400 after rst");

    // Randomized traffic on instance A
    for (int i = 0; i < 64; i++) txn(0, 0, 1, 32'h800 + 32'(4*i), 2'd2, $urandom, "rndA init");
    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 99);
      int s = $urandom_range(0, 9);
      logic [31:0] ad = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 63)
                                                    : 32'h800 + $urandom_range(0, 255);
      txn(0, r < 45 || r >= 90, r >= 45, ad,
          (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3, $urandom, "rndA");
    end
    // Randomized traffic on instance B
    for (int i = 0; i < 16; i++) txn(1, 0, 1, B_BASE + 32'(4*i), 2'd2, $urandom, "rndB init");
    for (int i = 0; i < 30; i++) begin
      int r = $urandom_range(0, 99);
      int q = $urandom_range(0, 9);
      logic [31:0] ad = (q == 0) ? B_BASE - 32'($urandom_range(1, 8)) :
                        (q == 1) ? B_BASE + 32'h400 + $urandom_range(0, 7) :
                                   B_BASE + $urandom_range(0, 63);
      txn(1, r < 50, r >= 50, ad, 2'($urandom_range(0, 2)), $urandom, "rndB");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
